// File: rtl/clock_domain_import_fifo_if.sv
// Bundles the source-domain toggle handshake and the destination-side FIFO
// drain port of clock_domain_import_fifo.
interface clock_domain_import_fifo_if #(
  parameter int pBits  = 8,
  parameter int pDepth = 4
);
  logic                           cdc_req;
  logic [pBits-1:0]               cdc_data;
  logic                           cdc_ack;
  logic [pBits-1:0]               data;
  logic                           valid;
  logic                           ready;
  logic [$clog2(pDepth+1)-1:0]    level;
  logic                           stall;

  modport slave (
    input  cdc_req, cdc_data, ready,
    output cdc_ack, data, valid, level, stall
  );

  modport master (
    output cdc_req, cdc_data, ready,
    input  cdc_ack, data, valid, level, stall
  );
endinterface

// File: rtl/clock_domain_import_fifo.sv
// Destination endpoint of a two-phase req/ack CDC handshake feeding a local
// first-word-fall-through FIFO; a full FIFO withholds ack to stall the source.
module clock_domain_import_fifo #(
  parameter int pBits       = 8,
  parameter int pDepth      = 4,
  parameter int pSyncStages = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  clock_domain_import_fifo_if.slave bus
);

  localparam int AW = $clog2(pDepth);
  localparam int LW = $clog2(pDepth + 1);

  logic [pSyncStages-1:0] sync_q, sync_d;
  logic                   ack_q, ack_d;
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]          level_q, level_d;
  logic [pBits-1:0]       mem_q [pDepth];

  logic req_sync;
  logic pending;
  logic full;
  logic empty;
  logic push;
  logic pop;

  assign req_sync = sync_q[pSyncStages-1];

  always_comb begin
    sync_d   = {sync_q[pSyncStages-2:0], bus.cdc_req};
    pending  = (req_sync != ack_q);
    full     = (level_q == LW'(pDepth));
    empty    = (level_q == '0);
    // A push is refused while full even if a pop frees a slot on the same edge.
    push     = pending && !full;
    pop      = !empty && bus.ready;
    ack_d    = push ? req_sync : ack_q;
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      ack_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      sync_q   <= sync_d;
      ack_q    <= ack_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage carries no reset; its contents only matter while valid is high.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.cdc_data;
  end

  assign bus.cdc_ack = ack_q;
  assign bus.data    = mem_q[rd_ptr_q];
  assign bus.valid   = !empty;
  assign bus.level   = level_q;
  assign bus.stall   = pending && full;

endmodule

// File: tb/tb_clock_domain_import_fifo.sv
// Directed self-checking bench for clock_domain_import_fifo (pBits=8, pDepth=4,
// pSyncStages=2).
module tb_clock_domain_import_fifo;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  clock_domain_import_fifo_if #(.pBits(8), .pDepth(4)) bus ();

  clock_domain_import_fifo #(
    .pBits(8), .pDepth(4), .pSyncStages(2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] word);
    bit done;
    done = 1'b0;
    bus.cdc_data = word;
    bus.cdc_req  = ~bus.cdc_req;
    for (int c = 0; c < 20 && !done; c++) begin
      tick();
      if (bus.cdc_ack === bus.cdc_req) done = 1'b1;
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL send_ack_timeout word=%h ack=%b required=%b", word, bus.cdc_ack, bus.cdc_req);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.cdc_req = 1'b0;
    bus.cdc_data = 8'h00;
    bus.ready = 1'b0;
    #3;
    total++; if (bus.cdc_ack !== 1'b0) begin bad++; $display("FAIL por_ack got=%b want=0", bus.cdc_ack); end
    total++; if (bus.valid !== 1'b0) begin bad++; $display("FAIL por_valid got=%b want=0", bus.valid); end
    total++; if (bus.level !== 3'd0) begin bad++; $display("FAIL por_level got=%0d want=0", bus.level); end
    total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL por_stall got=%b want=0", bus.stall); end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    send(8'h11);
    send(8'h22);
    total++; if (bus.level !== 3'd2) begin bad++; $display("FAIL pre_reset_level got=%0d want=2", bus.level); end
    rst_n = 1'b0;
    #1;
    total++; if (bus.cdc_ack !== 1'b0) begin bad++; $display("FAIL async_ack got=%b want=0", bus.cdc_ack); end
    total++; if (bus.valid !== 1'b0) begin bad++; $display("FAIL async_valid got=%b want=0", bus.valid); end
    total++; if (bus.level !== 3'd0) begin bad++; $display("FAIL async_level got=%0d want=0", bus.level); end
    total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL async_stall got=%b want=0", bus.stall); end
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick(); tick();
    total++; if (bus.valid !== 1'b0 || bus.level !== 3'd0 || bus.cdc_ack !== 1'b0)
      begin bad++; $display("FAIL post_release valid=%b level=%0d ack=%b want 0/0/0", bus.valid, bus.level, bus.cdc_ack); end
  endtask

  task automatic test_single();
    bus.ready = 1'b0;
    bus.cdc_data = 8'hA5;
    bus.cdc_req = 1'b1;
    tick();
    total++; if (bus.cdc_ack !== 1'b0 || bus.valid !== 1'b0)
      begin bad++; $display("FAIL single_edge1 ack=%b valid=%b want 0/0", bus.cdc_ack, bus.valid); end
    tick();
    total++; if (bus.cdc_ack !== 1'b0 || bus.valid !== 1'b0 || bus.stall !== 1'b0)
      begin bad++; $display("FAIL single_edge2 ack=%b valid=%b stall=%b want 0/0/0", bus.cdc_ack, bus.valid, bus.stall); end
    tick();
    total++; if (bus.cdc_ack !== 1'b1) begin bad++; $display("FAIL single_ack got=%b want=1", bus.cdc_ack); end
    total++; if (bus.valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b want=1", bus.valid); end
    total++; if (bus.data !== 8'hA5) begin bad++; $display("FAIL single_data got=%h want=a5", bus.data); end
    total++; if (bus.level !== 3'd1) begin bad++; $display("FAIL single_level got=%0d want=1", bus.level); end
    bus.ready = 1'b1;
    tick();
    bus.ready = 1'b0;
    total++; if (bus.valid !== 1'b0 || bus.level !== 3'd0)
      begin bad++; $display("FAIL single_pop valid=%b level=%0d want 0/0", bus.valid, bus.level); end
  endtask

  task automatic test_burst();
    bus.ready = 1'b0;
    for (int i = 1; i <= 4; i++) send(8'(i));
    total++; if (bus.level !== 3'd4) begin bad++; $display("FAIL burst_level got=%0d want=4", bus.level); end
    total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL burst_stall got=%b want=0", bus.stall); end
    bus.ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      total++;
      if (bus.valid !== 1'b1 || bus.data !== 8'(i))
        begin bad++; $display("FAIL burst_read%0d valid=%b data=%h want 1/%h", i, bus.valid, bus.data, 8'(i)); end
      tick();
    end
    bus.ready = 1'b0;
    total++; if (bus.valid !== 1'b0 || bus.level !== 3'd0)
      begin bad++; $display("FAIL burst_drained valid=%b level=%0d want 0/0", bus.valid, bus.level); end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp [5];
    logic       ack_before;
    exp = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h55};
    bus.ready = 1'b0;
    for (int i = 0; i < 4; i++) send(exp[i]);
    ack_before = bus.cdc_ack;
    bus.cdc_data = 8'h55;
    bus.cdc_req = ~bus.cdc_req;
    tick(); tick();
    for (int c = 0; c < 10; c++) begin
      total++;
      if (bus.stall !== 1'b1 || bus.cdc_ack !== ack_before || bus.level !== 3'd4)
        begin bad++; $display("FAIL bp_hold%0d stall=%b ack=%b level=%0d want 1/%b/4", c, bus.stall, bus.cdc_ack, bus.level, ack_before); end
      tick();
    end
    bus.ready = 1'b1;
    tick();
    bus.ready = 1'b0;
    total++; if (bus.level !== 3'd3 || bus.cdc_ack !== ack_before || bus.data !== 8'h11)
      begin bad++; $display("FAIL bp_pop_edge level=%0d ack=%b data=%h want 3/%b/11", bus.level, bus.cdc_ack, bus.data, ack_before); end
    total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL bp_pop_stall got=%b want=0", bus.stall); end
    tick();
    total++; if (bus.cdc_ack !== bus.cdc_req || bus.level !== 3'd4 || bus.stall !== 1'b0)
      begin bad++; $display("FAIL bp_push_edge ack=%b level=%0d stall=%b want %b/4/0", bus.cdc_ack, bus.level, bus.stall, bus.cdc_req); end
    bus.ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      total++;
      if (bus.valid !== 1'b1 || bus.data !== exp[i])
        begin bad++; $display("FAIL bp_read%0d valid=%b data=%h want 1/%h", i, bus.valid, bus.data, exp[i]); end
      tick();
    end
    bus.ready = 1'b0;
    total++; if (bus.valid !== 1'b0) begin bad++; $display("FAIL bp_drained valid=%b want=0", bus.valid); end
  endtask

  task automatic test_wrap();
    int got;
    got = 0;
    fork
      begin
        for (int i = 0; i < 10; i++) send(8'(8'h80 + i));
      end
      begin
        for (int c = 0; c < 400 && got < 10; c++) begin
          bus.ready = 1'($urandom_range(0, 1));
          total++;
          if (bus.level > 3'd4) begin bad++; $display("FAIL wrap_level got=%0d want<=4", bus.level); end
          if (bus.valid && bus.ready) begin
            total++;
            if (bus.data !== 8'(8'h80 + got))
              begin bad++; $display("FAIL wrap_data%0d got=%h want=%h", got, bus.data, 8'(8'h80 + got)); end
            got++;
          end
          tick();
        end
        bus.ready = 1'b0;
      end
    join
    total++; if (got != 10) begin bad++; $display("FAIL wrap_count got=%0d want=10", got); end
    total++; if (bus.valid !== 1'b0) begin bad++; $display("FAIL wrap_leftover valid=%b want=0", bus.valid); end
  endtask

  task automatic test_reset_req_high();
    bus.ready = 1'b0;
    rst_n = 1'b0;
    #1;
    bus.cdc_req = 1'b1;
    bus.cdc_data = 8'h3C;
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();
    total++; if (bus.valid !== 1'b0 || bus.cdc_ack !== 1'b0)
      begin bad++; $display("FAIL rrh_early valid=%b ack=%b want 0/0", bus.valid, bus.cdc_ack); end
    tick();
    total++; if (bus.cdc_ack !== 1'b1 || bus.level !== 3'd1 || bus.data !== 8'h3C)
      begin bad++; $display("FAIL rrh_capture ack=%b level=%0d data=%h want 1/1/3c", bus.cdc_ack, bus.level, bus.data); end
    for (int c = 0; c < 6; c++) tick();
    total++; if (bus.level !== 3'd1 || bus.stall !== 1'b0)
      begin bad++; $display("FAIL rrh_once level=%0d stall=%b want 1/0", bus.level, bus.stall); end
    bus.ready = 1'b1;
    tick();
    bus.ready = 1'b0;
    total++; if (bus.valid !== 1'b0) begin bad++; $display("FAIL rrh_drain valid=%b want=0", bus.valid); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_single();
    test_burst();
    test_backpressure();
    test_wrap();
    test_reset_req_high();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
